// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word receiver.
// No logic, no latency.
// No flow control.
package serial_pkg;

  // Framing states; PARITY is only reachable when the parity bit is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit counter must be able to hold the value DATA_W itself.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_hold_buf.sv
// One-entry holding register for received words with sticky overrun flag.
// Latency: a loaded word is visible on the cycle after load.
// Backpressure: a load while full and not draining is dropped and sets overrun.
module serial_hold_buf
  import serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic         overrun,
  input  logic         clr_ovr
);

  logic take;
  logic drop;

  // A new word fits if the slot is empty or is being handed off this cycle.
  assign take = load && (!valid || ready);
  assign drop = load && !take;

  // Slot contents and valid flag; dout keeps its last value after a handoff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (take) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Sticky overrun; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: ena-qualified bits framed by sync; optional parity bit via SERIAL_DESER_PARITY_EN.
// Latency: word valid one cycle after the ena cycle that sampled its last bit.
// Backpressure: one-entry valid/ready buffer; words arriving while it is full are dropped (sticky overrun).
module serial_deser
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              sync,
  input  logic              in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr
`ifdef SERIAL_DESER_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CW = cnt_w(DATA_W);
`ifdef SERIAL_DESER_PARITY_EN
  localparam int PW = DATA_W + 1;
`else
  localparam int PW = DATA_W;
`endif

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, shin;
  logic              done;
  logic [PW-1:0]     payload;
  logic [PW-1:0]     held;

  // Shift register contents after taking in the current bit.
  generate
    if (DATA_W == 1) begin : g_shin_1
      assign shin = in;
    end else if (MSB_FIRST) begin : g_shin_msb
      assign shin = {shreg[DATA_W-2:0], in};
    end else begin : g_shin_lsb
      assign shin = {in, shreg[DATA_W-1:1]};
    end
  endgenerate

  // Word handed to the buffer: parity flag rides on top of the data when enabled.
`ifdef SERIAL_DESER_PARITY_EN
  assign payload = {(^shreg) ^ in, shreg};
`else
  assign payload = shin;
`endif

  // Framing next-state: sync restarts a word from any state and beats completion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    done      = 1'b0;
    if (ena && sync) begin
      shreg_nxt = shin;
      if (DATA_W == 1) begin
`ifdef SERIAL_DESER_PARITY_EN
        state_nxt = PARITY;
        cnt_nxt   = CW'(1);
`else
        state_nxt = IDLE;
        cnt_nxt   = '0;
        done      = 1'b1;
`endif
      end else begin
        state_nxt = SHIFT;
        cnt_nxt   = CW'(1);
      end
    end else if (ena) begin
      case (state)
        SHIFT: begin
          shreg_nxt = shin;
          cnt_nxt   = cnt + CW'(1);
          if (cnt_nxt == CW'(DATA_W)) begin
`ifdef SERIAL_DESER_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done      = 1'b1;
`endif
          end
        end
        PARITY: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
`ifdef SERIAL_DESER_PARITY_EN
          done      = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Framing state, counter, shifter and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  serial_hold_buf #(
    .W (PW)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (done),
    .din     (payload),
    .dout    (held),
    .valid   (out_valid),
    .ready   (out_ready),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  assign out_data = held[DATA_W-1:0];
`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = held[DATA_W];
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: MSB-first and LSB-first instances share one stimulus stream.
// A bit-list model predicts the outputs; directed sequences pin known words, then random traffic.
// Outputs are compared on every falling edge; inputs change 2 time units after the rising edge.
module tb_serial_deser;

`ifdef SERIAL_DESER_PARITY_EN
  localparam int NEED = 9;
`else
  localparam int NEED = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0, sync = 1'b0, din = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;
  logic [7:0] data_m, data_l;
  logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef SERIAL_DESER_PARITY_EN
  logic perr_m, perr_l;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  serial_deser #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ena(ena), .sync(sync), .in(din),
    .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .busy(busy_m), .overrun(ovr_m), .clr_ovr(clr_ovr)
`ifdef SERIAL_DESER_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  serial_deser #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ena(ena), .sync(sync), .in(din),
    .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .busy(busy_l), .overrun(ovr_l), .clr_ovr(clr_ovr)
`ifdef SERIAL_DESER_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of bits received since the last sync, plus the output slot.
  bit         q[$];
  bit         m_act = 1'b0;
  logic [7:0] m_dm = '0, m_dl = '0;
  bit         m_v = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  bit         m_done, m_set, m_p;
  logic [7:0] wm, wl;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_act = 1'b0; m_dm = '0; m_dl = '0; m_v = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_set  = 1'b0;
      if (ena) begin
        if (sync) begin
          q.delete();
          q.push_back(din);
          m_act = 1'b1;
        end else if (m_act) begin
          q.push_back(din);
        end
        if (m_act && q.size() == NEED) begin
          m_done = 1'b1;
          m_act  = 1'b0;
        end
      end
      if (m_done) begin
        wm = '0;
        wl = '0;
        for (int i = 0; i < 8; i++) begin
          wm = {wm[6:0], q[i]};
          wl[i] = q[i];
        end
        m_p = (NEED == 9) ? q[NEED-1] : 1'b0;
        q.delete();
        if (!m_v || out_ready) begin
          m_dm = wm; m_dl = wl; m_perr = (^wm) ^ m_p; m_v = 1'b1;
        end else begin
          m_set = 1'b1;
        end
      end else if (m_v && out_ready) begin
        m_v = 1'b0;
      end
      if (m_set) m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("data_m", data_m, m_dm);
      check("data_l", data_l, m_dl);
      check("valid_m", valid_m, m_v);
      check("valid_l", valid_l, m_v);
      check("busy_m", busy_m, m_act);
      check("busy_l", busy_l, m_act);
      check("ovr_m", ovr_m, m_ovr);
      check("ovr_l", ovr_l, m_ovr);
`ifdef SERIAL_DESER_PARITY_EN
      check("perr_m", perr_m, m_perr);
      check("perr_l", perr_l, m_perr);
`endif
    end
  end

  task automatic bit_cyc(input bit e, input bit s, input bit b);
    @(posedge clk);
    #2;
    ena = e; sync = s; din = b;
  endtask

  // Sends v[n-1] first; one ena every 'stride' cycles; returns after the last bit is sampled.
  task automatic send_bits(input logic [15:0] v, input int n, input int stride, input bit rdy_last);
    for (int i = n - 1; i >= 0; i--) begin
      bit_cyc(1'b1, i == n - 1, v[i]);
      if (i == 0 && rdy_last) out_ready = 1'b1;
      for (int k = 1; k < stride; k++) bit_cyc(1'b0, 1'b0, 1'b0);
    end
    if (stride == 1) bit_cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input int stride, input bit rdy_last);
    if (NEED == 9) send_bits({7'd0, w, ^w}, 9, stride, rdy_last);
    else send_bits({8'd0, w}, 8, stride, rdy_last);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 cmp_on = 1'b1;
    check("rst_data", data_m, 8'h00);
    check("rst_valid", valid_m, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Known word, both orders; valid one cycle after the last ena, then drained.
    out_ready = 1'b1;
    send_word(8'hA5, 1, 1'b0);
    check("a5_valid", valid_m, 1'b1);
    check("a5_m", data_m, 8'hA5);
    check("a5_l", data_l, 8'hA5);
    bit_cyc(1'b0, 1'b0, 1'b0);
    check("a5_drain", valid_m, 1'b0);
    send_word(8'hC0, 1, 1'b0);
    check("c0_m", data_m, 8'hC0);
    check("03_l", data_l, 8'h03);

    // Sparse ena with a re-sync after 4 bits of a partial word.
    send_bits(16'h000B, 4, 3, 1'b0);
    check("partial_busy", busy_m, 1'b1);
    send_word(8'h3C, 3, 1'b0);
    check("3c_m", data_m, 8'h3C);
    check("3c_l", data_l, 8'h3C);

    // Full buffer: second word dropped, overrun sticky until cleared.
    out_ready = 1'b0;
    send_word(8'h11, 1, 1'b0);
    send_word(8'h22, 1, 1'b0);
    check("ovr_data", data_m, 8'h11);
    check("ovr_set", ovr_m, 1'b1);
    @(posedge clk); #2 clr_ovr = 1'b1;
    @(posedge clk); #2 clr_ovr = 1'b0;
    check("ovr_clr", ovr_m, 1'b0);
    send_word(8'h33, 1, 1'b1);
    check("33_data", data_m, 8'h33);
    check("33_ovr", ovr_m, 1'b0);
    check("33_valid", valid_m, 1'b1);

    // Reset in the middle of a word, then a clean word.
    send_bits(16'h000F, 4, 1, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_data", data_m, 8'h00);
    check("mid_rst_valid", valid_m, 1'b0);
    check("mid_rst_busy", busy_m, 1'b0);
    check("mid_rst_ovr", ovr_m, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    send_word(8'h5A, 1, 1'b0);
    check("5a_m", data_m, 8'h5A);
    check("5a_l", data_l, 8'h5A);
    check("5a_valid", valid_m, 1'b1);

`ifdef SERIAL_DESER_PARITY_EN
    send_bits({7'd0, 8'h07, 1'b1}, 9, 1, 1'b0);
    check("par_ok", perr_m, 1'b0);
    send_bits({7'd0, 8'h07, 1'b0}, 9, 1, 1'b0);
    check("par_bad", perr_m, 1'b1);
    check("par_data", data_m, 8'h07);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      ena       = ($urandom_range(3) != 0);
      sync      = ($urandom_range(15) == 0);
      din       = $urandom_range(1);
      out_ready = $urandom_range(1);
      clr_ovr   = ($urandom_range(19) == 0);
    end
    bit_cyc(1'b0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    bit_cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
